// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and lane helpers for the load/store data memory
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Little-endian byte-lane enables for a store; reserved size enables nothing.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << off;
            SZ_HALF: lane_mask = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    // Pick the addressed byte/half out of a word and extend it; words pass through.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic zext);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: load_extend = zext ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_HALF: load_extend = zext ? {16'h0, h} : {{16{h[15]}}, h};
            default: load_extend = word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - combinational store lane replicate/mask and load select/extend
// Ports: size/off/zext describe the access, st_data is the right-aligned store value,
// rd_word is the addressed memory word; wmask/wr_word drive the array write, ld_data is
// the extended load result, align_err flags misalignment or the reserved size.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        zext,
    input  logic [31:0] st_data,
    input  logic [31:0] rd_word,
    output logic [3:0]  wmask,
    output logic [31:0] wr_word,
    output logic [31:0] ld_data,
    output logic        align_err
);

    always_comb begin
        align_err = 1'b0;
        case (size)
            SZ_BYTE: align_err = 1'b0;
            SZ_HALF: align_err = off[0];
            SZ_WORD: align_err = (off != 2'b00);
            default: align_err = 1'b1;
        endcase
    end

    // Replicating the store value across lanes lets the mask alone pick the target lane.
    always_comb begin
        wr_word = st_data;
        case (size)
            SZ_BYTE: wr_word = {4{st_data[7:0]}};
            SZ_HALF: wr_word = {2{st_data[15:0]}};
            default: wr_word = st_data;
        endcase
    end

    assign wmask   = align_err ? 4'b0000 : lane_mask(size, off);
    assign ld_data = load_extend(rd_word, size, off, zext);

endmodule

// File: rtl/data_mem_ls.sv
// rtl/data_mem_ls.sv - byte-addressed data memory with load/store handshake and wait states
// Ports: clk/rst (sync, active-high); req_valid/req_ready handshake with req_we, req_size,
// req_unsigned, addr, data_in; rsp_valid pulse with data_out and rsp_err.
// Optional macro DMEM_BOUNDS_CHECK_EN: nonzero address bits above the array flag an error.
module data_mem_ls
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 0,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic        rsp_valid,
    output logic [31:0] data_out,
    output logic        rsp_err
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [1:0]       ST_AFTER_ACCEPT = (WAIT_CYCLES > 0) ? ST_BUSY : ST_RESP;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              we_q;
    logic [1:0]        size_q;
    logic              zext_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       data_q;
    logic              hi_err;

    logic [31:0] mem [2**ADDR_W];

    logic [31:0] rd_word;
    logic [3:0]  wmask;
    logic [31:0] wr_word;
    logic [31:0] ld_data;
    logic        align_err;
    logic        err;
    logic        accept;

    assign req_ready = (state == ST_IDLE) && !rst;
    assign accept    = req_valid && req_ready;
    assign rd_word   = mem[addr_q[ADDR_W+1:2]];
    assign err       = align_err || hi_err;

`ifdef DMEM_BOUNDS_CHECK_EN
    always_ff @(posedge clk) begin
        if (accept) begin
            hi_err <= |addr[31:ADDR_W+2];
        end
    end
`else
    // Upper address bits alias onto the array.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_W+2];
    assign hi_err = 1'b0;
`endif

    dmem_lane_align u_align (
        .size      (size_q),
        .off       (addr_q[1:0]),
        .zext      (zext_q),
        .st_data   (data_q),
        .rd_word   (rd_word),
        .wmask     (wmask),
        .wr_word   (wr_word),
        .ld_data   (ld_data),
        .align_err (align_err)
    );

    // Request fields are only captured on accept, so req_* changes while busy are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q   <= req_we;
            size_q <= req_size;
            zext_q <= req_unsigned;
            addr_q <= addr[ADDR_W+1:0];
            data_q <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            data_out  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_AFTER_ACCEPT;
                        cnt   <= '0;
                    end
                end
                ST_BUSY: begin
                    if (cnt == LAST_CNT) begin
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= err;
                    data_out  <= (err || we_q) ? 32'h0 : ld_data;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A reset landing in RESP suppresses the write so an aborted store leaves memory intact.
    always_ff @(posedge clk) begin
        if (!rst && (state == ST_RESP) && we_q) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[addr_q[ADDR_W+1:2]][8*i +: 8] <= wr_word[8*i +: 8];
                end
            end
        end
    end

endmodule
